lsu_arbiter: RTL
================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 Parameter MAX_LOCK, default 8: maximum consecutive cycles one requester may hold the LSU via lock.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 c_req_i, c_we_i, c_lock_i  in  1 each  core request, store flag, lock.
REQ-005 c_addr_i, c_wdata_i  in  32 each  core address, store data.
REQ-006 c_op_i  in  3  core loadsave_op encoding.
REQ-007 c_gnt_o, c_rvalid_o  out  1 each  core grant, read-data valid.
REQ-008 c_rdata_o  out  32  core load data.
REQ-009 d_req_i, d_we_i, d_lock_i, d_addr_i, d_wdata_i, d_op_i, d_gnt_o, d_rvalid_o, d_rdata_o: DMA/debug port, identical widths and meanings to the core port.
REQ-010 lsu_addr_o, lsu_st_data_o  out  32 each  shared LSU address, store data.
REQ-011 lsu_st_en_o  out  1  shared LSU store enable.
REQ-012 lsu_op_o  out  3  shared LSU op.
REQ-013 lsu_ld_data_i  in  32  shared LSU load data, combinational from lsu_addr_o.

Function
REQ-014 FSM states: IDLE, OWN_C, OWN_D; state, rr_last (last granted port) and lock_cnt are registers.
REQ-015 In IDLE, OWN_C or OWN_D without an active lock, the arbiter grants exactly one requester per cycle; if both request, the one not equal to rr_last wins.
REQ-016 A grant is combinational: gnt_o=1 in the same cycle as req_i; at most one gnt_o high per cycle.
REQ-017 On grant, lsu_addr_o/lsu_op_o/lsu_st_data_o are driven from the winner; lsu_st_en_o=winner we_i.
REQ-018 With no grant, lsu_st_en_o=0 and lsu_addr_o/lsu_st_data_o/lsu_op_o=0.
REQ-019 Granted load (we_i=0): lsu_ld_data_i captured at that clock edge; rdata_o holds it and rvalid_o=1 for exactly the next cycle to the granted port only.
REQ-020 Granted store: no rvalid_o pulse.
REQ-021 rdata_o holds its last captured value when rvalid_o=0.
REQ-022 rr_last updates to the winner at every granted edge.
REQ-023 Lock: grant to a requester with lock_i=1 moves FSM to OWN_C/OWN_D; while locked, only the owner is granted, other port gnt_o=0.
REQ-024 Owner dropping req_i or lock_i returns FSM to IDLE at the next edge; that cycle arbitrates normally per REQ-015.
REQ-025 lock_cnt counts granted cycles in OWN_x; at MAX_LOCK, lock is ignored for one arbitration, FSM returns to IDLE and the other port wins if requesting.
REQ-026 lock_cnt clears on entry to IDLE or ownership change; saturates, never wraps.
REQ-027 Requester holding req_i without grant keeps it asserted; arbiter never drops a granted transfer.
REQ-028 Worst-case wait for a non-locked requester: 1 cycle unlocked, MAX_LOCK+1 cycles against a locked owner.

Reset
REQ-029 On rst_ni=0 asynchronously: state=IDLE, rr_last=D (core wins first tie), lock_cnt=0, rvalid_o=0, rdata_o=0.
REQ-030 During reset, all gnt_o=0 and lsu_st_en_o=0; reset mid-lock abandons ownership, no rvalid_o after release.

Verification
REQ-031 Core load addr 0x10, LSU returns 0xDEADBEEF -> c_gnt_o=1 same cycle, next cycle c_rvalid_o=1, c_rdata_o=0xDEADBEEF, d_rvalid_o=0.
REQ-032 Both request continuously after reset, no lock -> grants alternate C,D,C,D; first grant to C.
REQ-033 DMA store 0x1000 data 0x55 with lock, core requesting -> d_gnt_o for 8 cycles, c_gnt_o=1 on cycle 9, lock_cnt cleared.
REQ-034 Core locked, drops lock after 3 cycles, DMA waiting -> DMA granted on the cycle lock drops.
REQ-035 rst_ni low mid-lock, mid-load -> gnt_o, rvalid_o, lsu_st_en_o all 0 immediately; after release core wins first tie.

Source files
------------

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin arbiter with bounded lock sharing one LSU between the core and a DMA/debug port
module lsu_arbiter #(
  parameter int MAX_LOCK = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic        c_lock_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  input  logic [2:0]  c_op_i,
  output logic        c_gnt_o,
  output logic        c_rvalid_o,
  output logic [31:0] c_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic        d_lock_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [2:0]  d_op_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  output logic        lsu_st_en_o,
  output logic [2:0]  lsu_op_o,
  input  logic [31:0] lsu_ld_data_i
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;
  state_t state, state_nxt;
  logic rr_last;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic cnt_max, own_c, own_d, gnt_c, gnt_d;
  assign cnt_max = lock_cnt == CW'(MAX_LOCK);
  assign own_c = state == OWN_C && c_req_i && c_lock_i && !cnt_max;
  assign own_d = state == OWN_D && d_req_i && d_lock_i && !cnt_max;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      rr_last <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (gnt_c || gnt_d) rr_last <= gnt_d;
    end
  // lock_cnt includes the grant that took ownership, so an owner holds at most MAX_LOCK cycles
  always_comb begin
    state_nxt = (gnt_c && c_lock_i && !cnt_max) ? OWN_C : (gnt_d && d_lock_i && !cnt_max) ? OWN_D : IDLE;
    lock_cnt_nxt = state_nxt == IDLE ? '0 : state_nxt != state ? CW'(1) : cnt_max ? lock_cnt : lock_cnt + 1'b1;
  end
  // rr_last=1 means the DMA port won last, so the core wins the next tie
  always_comb begin
    gnt_c = rst_ni && c_req_i && (own_c || (!own_d && (!d_req_i || rr_last)));
    gnt_d = rst_ni && d_req_i && !own_c && (own_d || !c_req_i || !rr_last);
    c_gnt_o = gnt_c;
    d_gnt_o = gnt_d;
    lsu_addr_o = gnt_c ? c_addr_i : gnt_d ? d_addr_i : '0;
    lsu_st_data_o = gnt_c ? c_wdata_i : gnt_d ? d_wdata_i : '0;
    lsu_op_o = gnt_c ? c_op_i : gnt_d ? d_op_i : '0;
    lsu_st_en_o = gnt_c ? c_we_i : gnt_d ? d_we_i : 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      c_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      c_rdata_o <= '0;
      d_rdata_o <= '0;
    end else begin
      c_rvalid_o <= gnt_c && !c_we_i;
      d_rvalid_o <= gnt_d && !d_we_i;
      if (gnt_c && !c_we_i) c_rdata_o <= lsu_ld_data_i;
      if (gnt_d && !d_we_i) d_rdata_o <= lsu_ld_data_i;
    end
endmodule
